// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - round-robin arbiter with short bus lock in front of a single-port SRAM
// Optional per-port stall counters: define SRAM_ARB_STALL_CNT_EN.
module sram_rr_arbiter #(
    parameter int NumPorts      = 2,
    parameter int AddrWidth     = 64,
    parameter int DataWidth     = 64,
    parameter int MaxLockCycles = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumPorts-1:0]             req_i,
    input  logic [NumPorts-1:0]             we_i,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i,
    input  logic [NumPorts*DataWidth/8-1:0] be_i,
    input  logic [NumPorts*DataWidth-1:0]   wdata_i,
    input  logic [NumPorts-1:0]             lock_i,
    output logic [NumPorts-1:0]             gnt_o,
    output logic [NumPorts-1:0]             rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic [DataWidth/8-1:0]          mem_be_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    input  logic [DataWidth-1:0]            mem_rdata_i
`ifdef SRAM_ARB_STALL_CNT_EN
    ,
    output logic [NumPorts*32-1:0]          stall_cnt_o
`endif
);

    localparam int BeWidth  = DataWidth / 8;
    localparam int PtrWidth = $clog2(NumPorts);
    localparam int CntWidth = $clog2(MaxLockCycles + 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t                state_q;
    logic [PtrWidth-1:0]   rr_ptr_q;
    logic [PtrWidth-1:0]   owner_q;
    logic [CntWidth-1:0]   lock_cnt_q;
    logic [NumPorts-1:0]   rvalid_q;

    logic                  rr_found;
    logic [PtrWidth-1:0]   rr_idx;
    logic                  lock_expired;
    logic                  gnt_valid;
    logic [PtrWidth-1:0]   gnt_idx;
    logic [PtrWidth-1:0]   next_ptr;

    // First requester at or after the pointer, wrapping at NumPorts-1.
    always_comb begin
        int j;
        rr_found = 1'b0;
        rr_idx   = '0;
        j        = 0;
        for (int off = 0; off < NumPorts; off++) begin
            j = int'(rr_ptr_q) + off;
            if (j >= NumPorts) begin
                j = j - NumPorts;
            end
            if (!rr_found && req_i[j]) begin
                rr_found = 1'b1;
                rr_idx   = PtrWidth'(j);
            end
        end
    end

    assign lock_expired = (state_q == ST_LOCKED) &&
                          (lock_cnt_q == CntWidth'(MaxLockCycles));

    // An expired lock falls back to plain round-robin; the pointer already sits past the owner.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (!rst_i) begin
            if (state_q == ST_LOCKED && !lock_expired) begin
                if (req_i[owner_q]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = owner_q;
                end
            end else if (rr_found) begin
                gnt_valid = 1'b1;
                gnt_idx   = rr_idx;
            end
        end
    end

    assign gnt_o     = gnt_valid ? (NumPorts'(1) << gnt_idx) : '0;
    assign mem_req_o = |gnt_o;
    assign next_ptr  = (gnt_idx == PtrWidth'(NumPorts - 1)) ? '0 : gnt_idx + PtrWidth'(1);

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (gnt_o[i]) begin
                mem_we_o    = we_i[i];
                mem_addr_o  = addr_i[i*AddrWidth +: AddrWidth];
                mem_be_o    = be_i[i*BeWidth +: BeWidth];
                mem_wdata_o = wdata_i[i*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            rvalid_q   <= '0;
        end else begin
            rvalid_q <= gnt_o;
            if (gnt_valid) begin
                rr_ptr_q <= next_ptr;
            end
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid && lock_i[gnt_idx]) begin
                        state_q    <= ST_LOCKED;
                        owner_q    <= gnt_idx;
                        lock_cnt_q <= CntWidth'(1);
                    end
                end
                ST_LOCKED: begin
                    if (lock_expired || !gnt_valid) begin
                        state_q    <= ST_IDLE;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + CntWidth'(1);
                        if (!lock_i[owner_q]) begin
                            state_q    <= ST_IDLE;
                            lock_cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    lock_cnt_q <= '0;
                end
            endcase
        end
    end

    // A response in flight when reset arrives is dropped, not delivered.
    assign rvalid_o = rvalid_q & {NumPorts{~rst_i}};
    assign rdata_o  = mem_rdata_i;

`ifdef SRAM_ARB_STALL_CNT_EN
    for (genvar g = 0; g < NumPorts; g++) begin : g_stall
        logic [31:0] cnt_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (req_i[g] && !gnt_o[g] && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
        assign stall_cnt_o[g*32 +: 32] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb/tb_sram_rr_arbiter.sv - scoreboard bench for sram_rr_arbiter with a behavioural SRAM
module tb_sram_rr_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   req, we, lock;
    logic [63:0]  a0, a1, wd0, wd1;
    logic [7:0]   be0, be1;
    logic [1:0]   gnt, rvalid;
    logic [63:0]  rdata;
    logic         mem_req, mem_we;
    logic [63:0]  mem_addr, mem_wdata, mem_rdata;
    logic [7:0]   mem_be;
`ifdef SRAM_ARB_STALL_CNT_EN
    logic [63:0]  stall_cnt;
`endif

    sram_rr_arbiter #(
        .NumPorts(2), .AddrWidth(64), .DataWidth(64), .MaxLockCycles(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
        .addr_i({a1, a0}), .be_i({be1, be0}), .wdata_i({wd1, wd0}), .lock_i(lock),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
`ifdef SRAM_ARB_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'd0;
        mem_rdata = 64'd0;
    end
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_be[b]) mem[mem_addr[8:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[8:3]];
            end
        end
    end

    typedef struct {
        logic [1:0]  gnt;
        logic        we;
        logic [63:0] addr;
        logic        rsp;
        logic [63:0] rdata;
        logic        chk;
    } gexp_t;

    typedef struct {
        logic [1:0]  port;
        logic [63:0] rdata;
        logic        chk;
        int          cyc;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t g;
    rexp_t r;
    int    checks = 0;
    int    errors = 0;
    int    mon_cyc = 0;

    always @(negedge clk) begin
        if (rvalid != 2'b00) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected cyc %0d got %b want 00", mon_cyc, rvalid);
            end else begin
                r = rq.pop_front();
                if (rvalid !== r.port || mon_cyc != r.cyc) begin
                    errors++;
                    $display("FAIL rvalid cyc %0d got %b want %b at cyc %0d", mon_cyc, rvalid, r.port, r.cyc);
                end
                if (r.chk) begin
                    checks++;
                    if (rdata !== r.rdata) begin
                        errors++;
                        $display("FAIL rdata cyc %0d got %h want %h", mon_cyc, rdata, r.rdata);
                    end
                end
            end
        end else if (rq.size() != 0 && rq[0].cyc <= mon_cyc) begin
            checks++;
            errors++;
            r = rq.pop_front();
            $display("FAIL rvalid_missing cyc %0d got 00 want %b", mon_cyc, r.port);
        end
        if (gq.size() != 0) begin
            g = gq.pop_front();
            checks++;
            if (gnt !== g.gnt || mem_req !== (|g.gnt) || mem_addr !== g.addr || mem_we !== g.we) begin
                errors++;
                $display("FAIL grant cyc %0d got gnt=%b req=%b we=%b addr=%h want gnt=%b req=%b we=%b addr=%h",
                         mon_cyc, gnt, mem_req, mem_we, mem_addr, g.gnt, |g.gnt, g.we, g.addr);
            end
            if (g.gnt != 2'b00 && g.rsp)
                rq.push_back('{port: g.gnt, rdata: g.rdata, chk: g.chk, cyc: mon_cyc + 1});
        end
        mon_cyc++;
    end

    task automatic step(input logic [1:0] eg, input logic rsp, input logic [63:0] rd, input logic chk);
        gexp_t e;
        e.gnt   = eg;
        e.we    = (eg == 2'b01) ? we[0] : (eg == 2'b10) ? we[1] : 1'b0;
        e.addr  = (eg == 2'b01) ? a0 : (eg == 2'b10) ? a1 : 64'd0;
        e.rsp   = rsp;
        e.rdata = rd;
        e.chk   = chk;
        gq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 2'b11; we = 2'b00; lock = 2'b00;
        a0 = 64'h0; a1 = 64'h8; wd0 = 64'h0; wd1 = 64'h0; be0 = 8'hFF; be1 = 8'hFF;
        @(posedge clk);
        #1;
        // reset held with both requesting
        repeat (3) step(2'b00, 1'b0, 64'd0, 1'b0);
        rst = 1'b0;
        // fairness, first grant to port 0
        repeat (3) begin
            step(2'b01, 1'b1, 64'd0, 1'b1);
            step(2'b10, 1'b1, 64'd0, 1'b1);
        end
        // write, read back, partial write, read back
        req = 2'b10; we = 2'b10; a1 = 64'h80; wd1 = 64'hDEADBEEF_CAFEF00D;
        step(2'b10, 1'b1, 64'd0, 1'b0);
        we = 2'b00;
        step(2'b10, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b1);
        we = 2'b10; be1 = 8'h0F; wd1 = 64'h11223344_55667788;
        step(2'b10, 1'b1, 64'd0, 1'b0);
        we = 2'b00; be1 = 8'hFF;
        step(2'b10, 1'b1, 64'hDEADBEEF_55667788, 1'b1);
        a1 = 64'h8;
        // lock held to the limit, then port 1
        req = 2'b11; lock = 2'b01;
        repeat (4) step(2'b01, 1'b1, 64'd0, 1'b1);
        step(2'b10, 1'b1, 64'd0, 1'b1);
`ifdef SRAM_ARB_STALL_CNT_EN
        checks++;
        if (stall_cnt[63:32] !== 32'd7) begin
            errors++;
            $display("FAIL stall_cnt1 got %0d want 7", stall_cnt[63:32]);
        end
`endif
        req = 2'b00; lock = 2'b00;
        step(2'b00, 1'b0, 64'd0, 1'b0);
        // lock released by request drop
        req = 2'b11; lock = 2'b01;
        step(2'b01, 1'b1, 64'd0, 1'b1);
        req = 2'b10; lock = 2'b00;
        step(2'b00, 1'b0, 64'd0, 1'b0);
        step(2'b10, 1'b1, 64'd0, 1'b1);
        // lock released by lock_i drop
        req = 2'b11; lock = 2'b01;
        step(2'b01, 1'b1, 64'd0, 1'b1);
        lock = 2'b00;
        step(2'b01, 1'b1, 64'd0, 1'b1);
        step(2'b10, 1'b1, 64'd0, 1'b1);
        // reset mid-operation drops the response and the lock
        req = 2'b01; lock = 2'b01;
        step(2'b01, 1'b0, 64'd0, 1'b0);
        rst = 1'b1;
        step(2'b00, 1'b0, 64'd0, 1'b0);
        rst = 1'b0; req = 2'b11; lock = 2'b00;
        step(2'b01, 1'b1, 64'd0, 1'b1);
        step(2'b10, 1'b1, 64'd0, 1'b1);
        req = 2'b00;
        repeat (2) step(2'b00, 1'b0, 64'd0, 1'b0);
        checks++;
        if (rq.size() != 0 || gq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0", rq.size(), gq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
